// File: rtl/cr_osf_ib_split_pkg.sv
// Shared types and constants for the OSF inbound splitter.
// Holds the merged stream bus, the TLV header layout, TLV type codes,
// RQE frame-size codes, the debug control word and the splitter state codes.
package cr_osf_ib_split_pkg;

  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tuser;   // [0] SOT, [1] EOT
    logic [7:0]  tstrb;
    logic        tlast;
  } axi4s_dp_bus_t;

  // First word of every TLV.
  typedef struct packed {
    logic [31:0] rsvd;
    logic [3:0]  frame_size;
    logic        last_of_command;
    logic [2:0]  rsvd1;
    logic [15:0] tlv_len;
    logic [7:0]  tlv_type;
  } tlv_word_0_t;

  typedef struct packed {
    logic [5:0] rsvd;
    logic [1:0] rd_mode;  // 1: hold in DF, 2: hold in PF, 0/3: normal
  } debug_ctl_t;

  // Type code 0 is reserved: it marks "no TLV open" in the splitter.
  localparam logic [7:0] TLV_NONE           = 8'd0;
  localparam logic [7:0] TLV_RQE            = 8'd1;
  localparam logic [7:0] TLV_CQE            = 8'd2;
  localparam logic [7:0] TLV_DATA           = 8'd3;
  localparam logic [7:0] TLV_DATA_UNK       = 8'd4;
  localparam logic [7:0] TLV_LZ77           = 8'd5;
  localparam logic [7:0] FRMD_USER_NULL     = 8'd6;
  localparam logic [7:0] FRMD_USER_PI16     = 8'd7;
  localparam logic [7:0] FRMD_USER_PI64     = 8'd8;
  localparam logic [7:0] FRMD_USER_VM       = 8'd9;
  localparam logic [7:0] FRMD_INT_APP       = 8'd10;
  localparam logic [7:0] FRMD_INT_SIP       = 8'd11;
  localparam logic [7:0] FRMD_INT_LIP       = 8'd12;
  localparam logic [7:0] FRMD_INT_VM        = 8'd13;
  localparam logic [7:0] FRMD_INT_VM_SHORT  = 8'd14;

  localparam logic [3:0] RQE_SIMPLE      = 4'd1;
  localparam logic [3:0] RQE_COMPOUND_4K = 4'd2;
  localparam logic [3:0] RQE_COMPOUND_8K = 4'd3;

  typedef logic [0:0] osf_ib_st_e;
  localparam osf_ib_st_e ISP_DF = 1'b0;
  localparam osf_ib_st_e ISP_PF = 1'b1;

endpackage

// File: rtl/cr_osf_ib_tlv_dec.sv
// Combinational TLV header classifier.
//   tdata           : candidate header word (only meaningful on SOT)
//   tlv_type        : raw type code
//   is_rqe/is_cqe   : request / completion headers
//   is_dat          : DATA, DATA_UNK or LZ77
//   is_frmd         : any FRMD_* header
//   frame_size      : RQE frame size code
//   last_of_command : data frame is the last of its command
module cr_osf_ib_tlv_dec
  import cr_osf_ib_split_pkg::*;
(
  input  logic [63:0] tdata,
  output logic [7:0]  tlv_type,
  output logic        is_rqe,
  output logic        is_dat,
  output logic        is_cqe,
  output logic        is_frmd,
  output logic [3:0]  frame_size,
  output logic        last_of_command
);

  tlv_word_0_t hdr;
  logic        unused_hdr;

  assign hdr             = tlv_word_0_t'(tdata);
  assign tlv_type        = hdr.tlv_type;
  assign frame_size      = hdr.frame_size;
  assign last_of_command = hdr.last_of_command;

  assign is_rqe  = (tlv_type == TLV_RQE);
  assign is_cqe  = (tlv_type == TLV_CQE);
  assign is_dat  = tlv_type inside {TLV_DATA, TLV_DATA_UNK, TLV_LZ77};
  assign is_frmd = tlv_type inside {FRMD_USER_NULL, FRMD_USER_PI16, FRMD_USER_PI64,
                                    FRMD_USER_VM, FRMD_INT_APP, FRMD_INT_SIP,
                                    FRMD_INT_LIP, FRMD_INT_VM, FRMD_INT_VM_SHORT};

  assign unused_hdr = ^{hdr.rsvd, hdr.rsvd1, hdr.tlv_len};

endmodule

// File: rtl/cr_osf_ib_split.sv
// OSF inbound splitter: steers the merged TLV stream to the data FIFO
// (RQE/DATA/DATA_UNK/LZ77) or the PDT FIFO (CQE/FRMD_*), switching at
// segment boundaries found by the outbound merge command rules.
//   ib_fifo_*        : merged input stream (rdata, empty, rd pop)
//   df_fifo_*        : data FIFO (full, wr push, wdata)
//   pf_fifo_*        : PDT FIFO (full, wr push, wdata)
//   debug_ctl_config : rd_mode phase hold for debug
//   proto_err        : one-cycle pulse per protocol violation
//   err_cnt/cmd_cnt  : saturating error count / wrapping command count
module cr_osf_ib_split
  import cr_osf_ib_split_pkg::*;
#(
  parameter int ERR_CNT_W = 16,
  parameter int CMD_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  axi4s_dp_bus_t        ib_fifo_rdata,
  input  logic                 ib_fifo_empty,
  output logic                 ib_fifo_rd,
  input  logic                 df_fifo_full,
  output logic                 df_fifo_wr,
  output axi4s_dp_bus_t        df_fifo_wdata,
  input  logic                 pf_fifo_full,
  output logic                 pf_fifo_wr,
  output axi4s_dp_bus_t        pf_fifo_wdata,
  input  debug_ctl_t           debug_ctl_config,
  output logic                 proto_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CMD_CNT_W-1:0] cmd_cnt
);

  osf_ib_st_e st;
  logic [7:0] cur_type;
  logic       simp_cmd, cmp_cmd, dat_val, last_frame, cqe_val, frmd_val;

  logic [7:0] typ;
  logic [3:0] fsz;
  logic       is_rqe, is_dat, is_cqe, is_frmd, loc;

  cr_osf_ib_tlv_dec u_dec (
    .tdata           (ib_fifo_rdata.tdata),
    .tlv_type        (typ),
    .is_rqe          (is_rqe),
    .is_dat          (is_dat),
    .is_cqe          (is_cqe),
    .is_frmd         (is_frmd),
    .frame_size      (fsz),
    .last_of_command (loc)
  );

  logic sot, eot, in_df, xfer, head, tlv_open, bad_type;
  logic df_dat_hd, pf_cqe_hd, pf_frmd_hd;
  logic dat_hit, cqe_hit, frmd_hit, done_cqe, done_frmd, go_pf, go_df;
  logic unused_cfg;

  assign sot   = ib_fifo_rdata.tuser[0];
  assign eot   = ib_fifo_rdata.tuser[1];
  assign in_df = (st == ISP_DF);
  assign xfer  = !ib_fifo_empty && !(in_df ? df_fifo_full : pf_fifo_full);
  assign head  = xfer && sot;

  // A TLV is open while cur_type holds a header type awaiting its EOT.
  assign tlv_open = (cur_type != TLV_NONE);

  assign ib_fifo_rd    = xfer;
  assign df_fifo_wr    = xfer && in_df;
  assign pf_fifo_wr    = xfer && !in_df;
  assign df_fifo_wdata = ib_fifo_rdata;
  assign pf_fifo_wdata = ib_fifo_rdata;

  assign bad_type  = in_df ? !(is_rqe || is_dat) : !(is_cqe || is_frmd);
  assign proto_err = (head && (tlv_open || bad_type)) || (xfer && !sot && !tlv_open);

  assign df_dat_hd  = head && in_df && is_dat;
  assign pf_cqe_hd  = head && !in_df && is_cqe;
  assign pf_frmd_hd = head && !in_df && is_frmd;

  // Include the current header so single-word TLVs (SOT+EOT together)
  // qualify their own boundary in the same cycle.
  assign dat_hit  = dat_val  || df_dat_hd;
  assign cqe_hit  = cqe_val  || pf_cqe_hd;
  assign frmd_hit = frmd_val || pf_frmd_hd;

  assign done_cqe  = (simp_cmd || (cmp_cmd && last_frame)) && cqe_hit;
  assign done_frmd = cmp_cmd && !last_frame && frmd_hit;

  assign go_pf = xfer && eot && in_df && dat_hit && (debug_ctl_config.rd_mode != 2'd1);
  assign go_df = xfer && eot && !in_df && (done_cqe || done_frmd) &&
                 (debug_ctl_config.rd_mode != 2'd2);

  assign unused_cfg = ^debug_ctl_config.rsvd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ISP_DF;
      cur_type   <= TLV_NONE;
      simp_cmd   <= 1'b0;
      cmp_cmd    <= 1'b0;
      dat_val    <= 1'b0;
      last_frame <= 1'b0;
      cqe_val    <= 1'b0;
      frmd_val   <= 1'b0;
      err_cnt    <= '0;
      cmd_cnt    <= '0;
    end else begin
      if (head)             cur_type <= eot ? TLV_NONE : typ;
      else if (xfer && eot) cur_type <= TLV_NONE;

      if (head && in_df && is_rqe) begin
        simp_cmd <= (fsz == RQE_SIMPLE);
        cmp_cmd  <= (fsz == RQE_COMPOUND_4K) || (fsz == RQE_COMPOUND_8K);
      end

      if (df_dat_hd) last_frame <= loc;

      if (go_pf)          dat_val <= 1'b0;
      else if (df_dat_hd) dat_val <= 1'b1;

      if (go_df) begin
        cqe_val  <= 1'b0;
        frmd_val <= 1'b0;
      end else begin
        if (pf_cqe_hd)  cqe_val  <= 1'b1;
        if (pf_frmd_hd) frmd_val <= 1'b1;
      end

      if (go_pf)      st <= ISP_PF;
      else if (go_df) st <= ISP_DF;

      if (proto_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
      if (go_df && done_cqe)            cmd_cnt <= cmd_cnt + CMD_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cr_osf_ib_split.sv
module tb_cr_osf_ib_split;
  import cr_osf_ib_split_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  axi4s_dp_bus_t ib_fifo_rdata = '0;
  logic          ib_fifo_empty = 1'b1;
  logic          ib_fifo_rd;
  logic          df_fifo_full = 1'b0;
  logic          df_fifo_wr;
  axi4s_dp_bus_t df_fifo_wdata;
  logic          pf_fifo_full = 1'b0;
  logic          pf_fifo_wr;
  axi4s_dp_bus_t pf_fifo_wdata;
  debug_ctl_t    cfg = '0;
  logic          proto_err;
  logic [15:0]   err_cnt;
  logic [31:0]   cmd_cnt;

  logic          unused_d2_rd, unused_d2_dfwr, unused_d2_pfwr, unused_d2_perr;
  axi4s_dp_bus_t unused_d2_dfw, unused_d2_pfw;
  logic [1:0]    d2_err_cnt;
  logic [31:0]   unused_d2_cmd;

  always #5 clk = ~clk;

  cr_osf_ib_split dut (
    .clk(clk), .rst_n(rst_n),
    .ib_fifo_rdata(ib_fifo_rdata), .ib_fifo_empty(ib_fifo_empty), .ib_fifo_rd(ib_fifo_rd),
    .df_fifo_full(df_fifo_full), .df_fifo_wr(df_fifo_wr), .df_fifo_wdata(df_fifo_wdata),
    .pf_fifo_full(pf_fifo_full), .pf_fifo_wr(pf_fifo_wr), .pf_fifo_wdata(pf_fifo_wdata),
    .debug_ctl_config(cfg), .proto_err(proto_err), .err_cnt(err_cnt), .cmd_cnt(cmd_cnt)
  );

  // Narrow error counter copy, same stimulus, for saturation.
  cr_osf_ib_split #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .ib_fifo_rdata(ib_fifo_rdata), .ib_fifo_empty(ib_fifo_empty), .ib_fifo_rd(unused_d2_rd),
    .df_fifo_full(df_fifo_full), .df_fifo_wr(unused_d2_dfwr), .df_fifo_wdata(unused_d2_dfw),
    .pf_fifo_full(pf_fifo_full), .pf_fifo_wr(unused_d2_pfwr), .pf_fifo_wdata(unused_d2_pfw),
    .debug_ctl_config(cfg), .proto_err(unused_d2_perr), .err_cnt(d2_err_cnt),
    .cmd_cnt(unused_d2_cmd)
  );

  axi4s_dp_bus_t ib_q[$], df_q[$], pf_q[$];
  int   n_chk = 0, n_fail = 0;
  int   n_perr = 0, n_df = 0, n_pf = 0;
  int   exp_err = 0, exp_cmd = 0;
  logic pend = 1'b0;
  logic df_full_v = 1'b0, pf_full_v = 1'b0;

  function automatic axi4s_dp_bus_t mk_hdr(logic [7:0] t, logic [3:0] fs, logic loc, logic eot);
    tlv_word_0_t   h;
    axi4s_dp_bus_t w;
    h = '0;
    h.tlv_type = t; h.frame_size = fs; h.last_of_command = loc;
    h.tlv_len = 16'($urandom); h.rsvd = $urandom;
    w = '0;
    w.tdata = h; w.tuser = {6'd0, eot, 1'b1}; w.tstrb = 8'hff; w.tlast = eot;
    return w;
  endfunction

  function automatic axi4s_dp_bus_t mk_body(logic eot);
    axi4s_dp_bus_t w;
    w = '0;
    w.tdata = {$urandom, $urandom}; w.tuser = {6'd0, eot, 1'b0};
    w.tstrb = 8'(1 + $urandom_range(0, 254)); w.tlast = eot;
    return w;
  endfunction

  task automatic push_word(axi4s_dp_bus_t w, bit to_pf);
    ib_q.push_back(w);
    if (to_pf) pf_q.push_back(w); else df_q.push_back(w);
  endtask

  task automatic send_tlv(logic [7:0] t, int n, logic [3:0] fs, logic loc, bit to_pf);
    for (int i = 0; i < n; i++)
      push_word((i == 0) ? mk_hdr(t, fs, loc, n == 1) : mk_body(i == n - 1), to_pf);
  endtask

  // One clock: inputs change 1 time unit after posedge, outputs are
  // scoreboarded at negedge.
  task automatic tick();
    axi4s_dp_bus_t e;
    @(posedge clk); #1;
    if (pend && ib_q.size() != 0) e = ib_q.pop_front();
    ib_fifo_empty = (ib_q.size() == 0);
    if (!ib_fifo_empty) ib_fifo_rdata = ib_q[0];
    df_fifo_full = df_full_v;
    pf_fifo_full = pf_full_v;
    @(negedge clk);
    if (ib_fifo_rd || df_fifo_wr || pf_fifo_wr || ib_fifo_empty) begin
      n_chk++;
      if ((ib_fifo_rd !== (df_fifo_wr | pf_fifo_wr)) || (df_fifo_wr && pf_fifo_wr) ||
          (df_fifo_wr && df_fifo_full) || (pf_fifo_wr && pf_fifo_full) ||
          (ib_fifo_empty && ib_fifo_rd)) begin
        n_fail++;
        $display("FAIL xfer_ctl: rd=%b df_wr=%b pf_wr=%b empty=%b df_full=%b pf_full=%b",
                 ib_fifo_rd, df_fifo_wr, pf_fifo_wr, ib_fifo_empty, df_fifo_full, pf_fifo_full);
      end
    end
    if (df_fifo_wr) begin
      n_df++; n_chk++;
      if (df_q.size() == 0) begin
        n_fail++; $display("FAIL df_word: got unexpected write %h, required none", df_fifo_wdata);
      end else begin
        e = df_q.pop_front();
        if (df_fifo_wdata !== e) begin
          n_fail++; $display("FAIL df_word: got %h, required %h", df_fifo_wdata, e);
        end
      end
    end
    if (pf_fifo_wr) begin
      n_pf++; n_chk++;
      if (pf_q.size() == 0) begin
        n_fail++; $display("FAIL pf_word: got unexpected write %h, required none", pf_fifo_wdata);
      end else begin
        e = pf_q.pop_front();
        if (pf_fifo_wdata !== e) begin
          n_fail++; $display("FAIL pf_word: got %h, required %h", pf_fifo_wdata, e);
        end
      end
    end
    if (proto_err) n_perr++;
    pend = ib_fifo_rd;
  endtask

  task automatic drain(string name, int budget);
    int c = 0;
    while (ib_q.size() != 0 && c < budget) begin tick(); c++; end
    n_chk++;
    if (ib_q.size() != 0 || df_q.size() != 0 || pf_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: left ib=%0d df=%0d pf=%0d after %0d cycles, required 0/0/0",
               name, ib_q.size(), df_q.size(), pf_q.size(), c);
      ib_q.delete(); df_q.delete(); pf_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++;
    if ({ib_fifo_rd, df_fifo_wr, pf_fifo_wr, proto_err} !== 4'b0 || err_cnt !== 16'd0 ||
        cmd_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_vals: rd/dfwr/pfwr/perr=%b%b%b%b err=%0d cmd=%0d, required 0",
               ib_fifo_rd, df_fifo_wr, pf_fifo_wr, proto_err, err_cnt, cmd_cnt);
    end
    #4 rst_n = 1'b1;
    repeat (2) tick();
    n_chk++;
    if (err_cnt !== 16'd0 || cmd_cnt !== 32'd0 || n_perr != 0) begin
      n_fail++;
      $display("FAIL post_reset: err=%0d cmd=%0d perr=%0d, required 0", err_cnt, cmd_cnt, n_perr);
    end
  endtask

  task automatic test_simple();
    int df0 = n_df, pf0 = n_pf;
    send_tlv(TLV_RQE, 2, RQE_SIMPLE, 1'b0, 1'b0);
    send_tlv(TLV_DATA, 4, 4'd0, 1'b1, 1'b0);
    send_tlv(TLV_CQE, 3, 4'd0, 1'b0, 1'b1);
    drain("simple", 100);
    exp_cmd++;
    n_chk++;
    if (n_df - df0 != 6 || n_pf - pf0 != 3) begin
      n_fail++;
      $display("FAIL simple_counts: df=%0d pf=%0d, required 6 and 3", n_df - df0, n_pf - pf0);
    end
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd) || err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL simple_cnt: cmd=%0d err=%0d, required %0d %0d", cmd_cnt, err_cnt, exp_cmd, exp_err);
    end
  endtask

  task automatic test_compound();
    send_tlv(TLV_RQE, 2, RQE_COMPOUND_4K, 1'b0, 1'b0);
    send_tlv(TLV_DATA, 3, 4'd0, 1'b0, 1'b0);
    send_tlv(FRMD_INT_APP, 2, 4'd0, 1'b0, 1'b1);
    drain("compound_f1", 100);
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd)) begin
      n_fail++; $display("FAIL compound_mid_cmd: cmd=%0d, required %0d", cmd_cnt, exp_cmd);
    end
    send_tlv(TLV_LZ77, 2, 4'd0, 1'b1, 1'b0);
    send_tlv(TLV_CQE, 2, 4'd0, 1'b0, 1'b1);
    drain("compound_f2", 100);
    exp_cmd++;
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd) || err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL compound_cnt: cmd=%0d err=%0d, required %0d %0d", cmd_cnt, err_cnt, exp_cmd, exp_err);
    end
  endtask

  task automatic test_frmd_null();
    send_tlv(TLV_RQE, 1, RQE_COMPOUND_8K, 1'b0, 1'b0);
    send_tlv(TLV_DATA_UNK, 2, 4'd0, 1'b0, 1'b0);
    send_tlv(FRMD_USER_NULL, 1, 4'd0, 1'b0, 1'b1);
    send_tlv(TLV_DATA, 1, 4'd0, 1'b1, 1'b0);
    send_tlv(TLV_CQE, 1, 4'd0, 1'b0, 1'b1);
    drain("frmd_null", 100);
    exp_cmd++;
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd) || err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL frmd_null_cnt: cmd=%0d err=%0d, required %0d %0d", cmd_cnt, err_cnt, exp_cmd, exp_err);
    end
  endtask

  task automatic test_backpressure();
    int pf0 = n_pf, hold = 0, rd_in_hold = 0, c = 0;
    send_tlv(TLV_RQE, 2, RQE_SIMPLE, 1'b0, 1'b0);
    send_tlv(TLV_DATA, 5, 4'd0, 1'b1, 1'b0);
    send_tlv(TLV_CQE, 3, 4'd0, 1'b0, 1'b1);
    while (ib_q.size() != 0 && c < 300) begin
      df_full_v = ~df_full_v;
      pf_full_v = (n_pf - pf0 == 1) && (hold < 10);
      if (pf_full_v) hold++;
      tick();
      if (pf_fifo_full && ib_fifo_rd) rd_in_hold++;
      c++;
    end
    df_full_v = 1'b0; pf_full_v = 1'b0;
    drain("backpressure", 10);
    exp_cmd++;
    n_chk++;
    if (hold != 10 || rd_in_hold != 0) begin
      n_fail++;
      $display("FAIL bp_hold: held=%0d rd_while_full=%0d, required 10 and 0", hold, rd_in_hold);
    end
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd) || err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL bp_cnt: cmd=%0d err=%0d, required %0d %0d", cmd_cnt, err_cnt, exp_cmd, exp_err);
    end
  endtask

  task automatic test_rd_mode();
    cfg.rd_mode = 2'd1;
    send_tlv(TLV_RQE, 2, RQE_SIMPLE, 1'b0, 1'b0);
    send_tlv(TLV_DATA, 2, 4'd0, 1'b1, 1'b0);
    send_tlv(TLV_DATA, 2, 4'd0, 1'b1, 1'b0);
    drain("rd_mode_hold", 100);
    cfg.rd_mode = 2'd0;
    send_tlv(TLV_DATA, 1, 4'd0, 1'b1, 1'b0);
    send_tlv(TLV_CQE, 2, 4'd0, 1'b0, 1'b1);
    drain("rd_mode_clear", 100);
    exp_cmd++;
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd) || err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL rd_mode_cnt: cmd=%0d err=%0d, required %0d %0d", cmd_cnt, err_cnt, exp_cmd, exp_err);
    end
  endtask

  task automatic test_errors();
    int p0 = n_perr;
    send_tlv(TLV_CQE, 2, 4'd0, 1'b0, 1'b0);             // CQE in data phase
    push_word(mk_hdr(TLV_DATA, 4'd0, 1'b1, 1'b0), 1'b0); // open DATA, no EOT
    send_tlv(TLV_DATA, 2, 4'd0, 1'b1, 1'b0);            // SOT mid-TLV
    send_tlv(TLV_CQE, 3, 4'd0, 1'b0, 1'b1);
    drain("errors_a", 100);
    exp_err += 2; exp_cmd++;
    n_chk++;
    if (n_perr - p0 != 2 || err_cnt !== 16'(exp_err) || d2_err_cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL err_two: pulses=%0d err=%0d err_w2=%0d, required 2 %0d 2",
               n_perr - p0, err_cnt, d2_err_cnt, exp_err);
    end
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd)) begin
      n_fail++; $display("FAIL err_cmd: cmd=%0d, required %0d", cmd_cnt, exp_cmd);
    end
    push_word(mk_body(1'b0), 1'b0);                      // orphan body word
    send_tlv(8'hF0, 1, 4'd0, 1'b0, 1'b0);               // unknown type
    send_tlv(FRMD_INT_APP, 1, 4'd0, 1'b0, 1'b0);        // FRMD in data phase
    drain("errors_b", 100);
    exp_err += 3;
    n_chk++;
    if (n_perr - p0 != 5 || err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL err_five: pulses=%0d err=%0d, required 5 %0d", n_perr - p0, err_cnt, exp_err);
    end
    n_chk++;
    if (d2_err_cnt !== 2'd3) begin
      n_fail++; $display("FAIL err_saturate: err_w2=%0d, required 3", d2_err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    send_tlv(TLV_RQE, 2, RQE_SIMPLE, 1'b0, 1'b0);
    push_word(mk_hdr(TLV_DATA, 4'd0, 1'b1, 1'b0), 1'b0);
    push_word(mk_body(1'b0), 1'b0);
    drain("reset_mid_pre", 100);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ib_fifo_rd, df_fifo_wr, pf_fifo_wr, proto_err} !== 4'b0 || err_cnt !== 16'd0 ||
        cmd_cnt !== 32'd0 || d2_err_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_vals: rd/dfwr/pfwr/perr=%b%b%b%b err=%0d cmd=%0d, required 0",
               ib_fifo_rd, df_fifo_wr, pf_fifo_wr, proto_err, err_cnt, cmd_cnt);
    end
    #2 rst_n = 1'b1;
    pend = 1'b0; exp_err = 0; exp_cmd = 0; p0 = n_perr;
    send_tlv(TLV_RQE, 2, RQE_SIMPLE, 1'b0, 1'b0);
    send_tlv(TLV_DATA, 3, 4'd0, 1'b1, 1'b0);
    send_tlv(TLV_CQE, 2, 4'd0, 1'b0, 1'b1);
    drain("reset_mid_post", 100);
    exp_cmd++;
    n_chk++;
    if (cmd_cnt !== 32'(exp_cmd) || err_cnt !== 16'd0 || n_perr != p0) begin
      n_fail++;
      $display("FAIL reset_recover: cmd=%0d err=%0d pulses=%0d, required 1 0 0",
               cmd_cnt, err_cnt, n_perr - p0);
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_compound();
    test_frmd_null();
    test_backpressure();
    test_rd_mode();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_osf_ib_split.md
# cr_osf_ib_split

Inbound splitter for the OSF TLV stream: the inverse of the outbound data/PDT merge. A single merged axi4s_dp_bus_t stream (data-path segment followed by PDT segment, repeated per frame) is read from an inbound FIFO and steered to a data FIFO (RQE, DATA, DATA_UNK, LZ77 TLVs) and a PDT FIFO (CQE, FRMD_* TLVs). Segment boundaries are found by the same command rules used on the outbound side. Protocol violations are flagged and counted.

## Interface
- ERR_CNT_W, 16, width of saturating protocol-error counter
- CMD_CNT_W, 32, width of wrapping completed-command counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ib_fifo_rdata  in  axi4s_dp_bus_t  merged stream word; tuser[0]=SOT, tuser[1]=EOT
- ib_fifo_empty  in  1  inbound FIFO empty
- ib_fifo_rd  out  1  inbound FIFO pop
- df_fifo_full  in  1  data FIFO full
- df_fifo_wr  out  1  data FIFO push
- df_fifo_wdata  out  axi4s_dp_bus_t  data FIFO word (ib_fifo_rdata, unmodified)
- pf_fifo_full  in  1  PDT FIFO full
- pf_fifo_wr  out  1  PDT FIFO push
- pf_fifo_wdata  out  axi4s_dp_bus_t  PDT FIFO word (ib_fifo_rdata, unmodified)
- debug_ctl_config  in  debug_ctl_t  rd_mode 1: hold in DF phase; rd_mode 2: hold in PF phase; 0/3: normal
- proto_err  out  1  one-cycle pulse per detected violation
- err_cnt  out  ERR_CNT_W  saturating violation count
- cmd_cnt  out  CMD_CNT_W  completed-command count, wraps

## Operation
- States: ISP_DF (route to data FIFO), ISP_PF (route to PDT FIFO). Reset state ISP_DF.
- Transfer condition xfer = !ib_fifo_empty && !dest_full, dest = df in ISP_DF, pf in ISP_PF. ib_fifo_rd = xfer; df_fifo_wr = xfer in ISP_DF; pf_fifo_wr = xfer in ISP_PF. Never both writes in one cycle.
- TLV head = xfer && SOT. On head, capture tlv_type (tlv_word_0_t) into cur_type; cleared on transferred EOT.
- ISP_DF head:
  - RQE: latch simp_cmd = (frame_size==RQE_SIMPLE), cmp_cmd = (frame_size in RQE_COMPOUND_4K/8K).
  - DATA/DATA_UNK/LZ77: set dat_val, latch last_frame = last_of_command.
  - Any other type: proto_err; word still routed to data FIFO.
- ISP_DF -> ISP_PF: transferred EOT with dat_val set and rd_mode!=1. Clears dat_val.
- ISP_PF head: CQE sets cqe_val; FRMD_USER_PI16/PI64/VM, FRMD_INT_APP/SIP/LIP/VM/VM_SHORT, FRMD_USER_NULL set frmd_val; any other type: proto_err, routed to PDT FIFO.
- ISP_PF -> ISP_DF (rd_mode!=2) on transferred EOT when: (simp_cmd && cqe_val) || (cmp_cmd && last_frame && cqe_val) || (cmp_cmd && !last_frame && frmd_val). Clears cqe_val, frmd_val. cmd_cnt increments when the exit was via cqe_val.
- FRMD_USER_NULL single-word TLV (SOT and EOT same word) qualifies frmd_val in the same cycle.
- SOT while a TLV is open (no EOT yet): proto_err, new TLV header taken.
- Non-SOT word with no open TLV: proto_err, routed by current state.
- err_cnt increments on each proto_err, saturates at all-ones.

## Timing
- Data path combinational: ib_fifo_rdata -> df/pf_fifo_wdata, zero latency; rd/wr same cycle as xfer.
- State, flags, counters update on clk edge after the transferred word.
- proto_err asserted in the cycle of the offending xfer (combinational from header decode), counter updates next edge.
- Full on non-selected destination has no effect. Full on selected destination stalls; no word lost or duplicated.
- Reset values: state ISP_DF, all flags 0, proto_err 0, err_cnt 0, cmd_cnt 0; rd/wr outputs 0 whenever empty. Reset mid-TLV discards partial state; next word must be SOT.

## Structure
- cr_osfPKG gains osf_ib_st_e {ISP_DF, ISP_PF}; TLV typedefs and RQE/FRMD constants reused from cr_structs.sv / existing packages.
- Sub-module cr_osf_ib_tlv_dec: combinational header classifier (is_rqe, is_dat, is_cqe, is_frmd, frame_size, last_of_command).

## Test plan
- Simple cmd: RQE(SIMPLE, 2 words), DATA(4 words, EOT), CQE(3 words) -> 6 writes df, 3 writes pf, cmd_cnt=1, state back to ISP_DF.
- Compound 2-frame: RQE(COMPOUND_4K), DATA(last=0), FRMD_INT_APP, DATA(last=1), CQE -> frames alternate correctly; cmd_cnt=1 only after CQE.
- Backpressure: pf_fifo_full held 10 cycles mid-CQE, df_fifo_full toggling -> ib_fifo_rd low only while selected dest full; output word sequence bit-exact.
- FRMD_USER_NULL single-word with compound last=0 -> immediate return to ISP_DF.
- Errors: CQE arriving in ISP_DF, SOT mid-TLV -> proto_err pulses twice, err_cnt=2; saturation check with ERR_CNT_W=2 after 5 errors -> 3.
- rd_mode=1 then 0: stream stays in df until mode cleared; async reset mid-DATA -> all outputs/counters 0, recovery on next RQE.
